// File: rtl/pmem_wb_responder_pkg.sv
// Shared types for the pmem Wishbone responder.
// Line, address and byte-select types plus the FSM state encoding.
package pmem_wb_responder_pkg;

  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [11:0]  lc3b_pmem_addr;
  typedef logic [15:0]  lc3b_pmem_sel;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DONE
  } pmem_state_e;

  localparam int PMEM_BYTES = 16;

endpackage

// File: rtl/pmem_wb_responder_if.sv
// Wishbone bus bundle between pmem_master and the responder.
// The master drives requests; the slave returns data and ACK.
interface pmem_wb_responder_if;
  import pmem_wb_responder_pkg::*;

  logic          CYC;
  logic          STB;
  logic          WE;
  lc3b_pmem_sel  SEL;
  lc3b_pmem_addr ADR;
  lc3b_pmem_line DAT_M;
  lc3b_pmem_line DAT_S;
  logic          ACK;
  logic          RTY;

  modport master (
    output CYC, STB, WE, SEL, ADR, DAT_M,
    input  DAT_S, ACK, RTY
  );

  modport slave (
    input  CYC, STB, WE, SEL, ADR, DAT_M,
    output DAT_S, ACK, RTY
  );

endinterface

// File: rtl/pmem_wb_responder_line_ram.sv
// Line RAM: 2**AW lines of 128 bits, byte write enables.
// Registered one-cycle read, contents survive reset.
module pmem_line_ram
  import pmem_wb_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output lc3b_pmem_line rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  lc3b_pmem_sel  wr_be,
  input  lc3b_pmem_line wr_data
);

  lc3b_pmem_line mem [2**AW];

  always_ff @(posedge clk) begin
    if (rd_en)
      rd_data <= mem[rd_addr];
    for (int i = 0; i < PMEM_BYTES; i++) begin
      if (wr_en && wr_be[i])
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/pmem_wb_responder.sv
// Wishbone pmem responder: latched request, fixed latency ACK,
// byte-masked line writes and read/write/abort counters.
module pmem_wb_responder
  import pmem_wb_responder_pkg::*;
#(
  parameter int LATENCY   = 10,
  parameter int DEPTH_LG2 = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pmem_wb_responder_if.slave   bus,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  output logic [15:0]          abort_count
);

  localparam logic [15:0] CTR_INIT = 16'(LATENCY - 1);

  pmem_state_e   state;
  logic [15:0]   ctr;
  lc3b_pmem_addr adr_q;
  lc3b_pmem_sel  sel_q;
  lc3b_pmem_line dat_q;
  logic          we_q;
  logic          ack_q;
  lc3b_pmem_line dat_s_q;

  logic                 req;
  logic                 rd_en;
  logic                 wr_en;
  logic [DEPTH_LG2-1:0] rd_addr;
  lc3b_pmem_line        rd_data;

  assign req = bus.CYC & bus.STB;

  // With LATENCY==1 the read must launch from the live bus address.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = adr_q[DEPTH_LG2-1:0];
    wr_en   = 1'b0;
    unique case (1'b1)
      state == S_IDLE: begin
        rd_addr = bus.ADR[DEPTH_LG2-1:0];
        rd_en   = req && (LATENCY == 1);
      end
      state == S_WAIT: rd_en = req && (ctr == 16'd1);
      state == S_RESP: wr_en = req && we_q;
      default: ;
    endcase
  end

  pmem_line_ram #(
    .AW (DEPTH_LG2)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (adr_q[DEPTH_LG2-1:0]),
    .wr_be   (sel_q),
    .wr_data (dat_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ctr         <= '0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      dat_s_q     <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      abort_count <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            adr_q <= bus.ADR;
            we_q  <= bus.WE;
            sel_q <= bus.SEL;
            dat_q <= bus.DAT_M;
            ctr   <= CTR_INIT;
            state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            abort_count <= abort_count + 16'd1;
            state       <= S_IDLE;
          end else if (ctr == 16'd1) begin
            state <= S_RESP;
          end else begin
            ctr <= ctr - 16'd1;
          end
        end
        S_RESP: begin
          if (!req) begin
            abort_count <= abort_count + 16'd1;
            state       <= S_IDLE;
          end else begin
            ack_q <= 1'b1;
            if (we_q) begin
              wr_count <= wr_count + 16'd1;
            end else begin
              rd_count <= rd_count + 16'd1;
              dat_s_q  <= rd_data;
            end
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ACK   = ack_q;
  assign bus.DAT_S = dat_s_q;
  assign bus.RTY   = 1'b0;

endmodule

// File: tb/tb_pmem_wb_responder.sv
// Directed bench for pmem_wb_responder against a cycle-count model.
// Outputs are compared every negedge; literal checks pin the model.
module tb_pmem_wb_responder;
  import pmem_wb_responder_pkg::*;

  localparam int L  = 10;
  localparam int DL = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic [15:0] abort_count;

  pmem_wb_responder_if bus ();

  pmem_wb_responder #(
    .LATENCY   (L),
    .DEPTH_LG2 (DL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rd_count    (rd_count),
    .wr_count    (wr_count),
    .abort_count (abort_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction accepted at edge n completes at edge n+L
  // unless req drops first; after completion one edge is dead.
  logic [127:0] mmem [int];
  bit           m_pend = 0;
  int           m_ecnt = 0;
  int           m_skip = 0;
  bit           m_we;
  int           m_adr;
  logic [15:0]  m_sel;
  logic [127:0] m_wd;
  bit           m_ack = 0;
  logic [127:0] m_dat = '0;
  int           m_rd = 0;
  int           m_wr = 0;
  int           m_ab = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_skip = 0; m_ack = 0; m_dat = '0;
      m_rd = 0; m_wr = 0; m_ab = 0;
    end else begin
      m_ack = 0;
      if (m_pend) begin
        m_ecnt++;
        if (!(bus.CYC && bus.STB)) begin
          m_ab = (m_ab + 1) % 65536;
          m_pend = 0;
        end else if (m_ecnt == L) begin
          m_ack = 1;
          if (m_we) begin
            logic [127:0] t;
            t = mmem.exists(m_adr) ? mmem[m_adr] : '0;
            for (int b = 0; b < 16; b++)
              if (m_sel[b]) t[8*b +: 8] = m_wd[8*b +: 8];
            mmem[m_adr] = t;
            m_wr = (m_wr + 1) % 65536;
          end else begin
            m_dat = mmem[m_adr];
            m_rd = (m_rd + 1) % 65536;
          end
          m_pend = 0;
          m_skip = 1;
        end
      end else if (m_skip > 0) begin
        m_skip--;
      end else if (bus.CYC && bus.STB) begin
        m_pend = 1;
        m_ecnt = 0;
        m_we   = bus.WE;
        m_adr  = int'(bus.ADR) % (1 << DL);
        m_sel  = bus.SEL;
        m_wd   = bus.DAT_M;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack",   128'(bus.ACK),     128'(m_ack));
      chk("rty",   128'(bus.RTY),     128'(0));
      chk("dat_s", bus.DAT_S,         m_dat);
      chk("rd_cnt", 128'(rd_count),   128'(m_rd));
      chk("wr_cnt", 128'(wr_count),   128'(m_wr));
      chk("ab_cnt", 128'(abort_count), 128'(m_ab));
    end
  end

  task automatic idle_bus();
    bus.CYC = 0; bus.STB = 0; bus.WE = 0;
    bus.SEL = '0; bus.ADR = '0; bus.DAT_M = '0;
  endtask

  task automatic drive(input bit we, input logic [11:0] a,
                       input logic [15:0] s, input logic [127:0] d);
    @(negedge clk); #1;
    bus.CYC = 1; bus.STB = 1; bus.WE = we;
    bus.ADR = a; bus.SEL = s; bus.DAT_M = d;
  endtask

  task automatic xfer(input bit we, input logic [11:0] a,
                      input logic [15:0] s, input logic [127:0] d,
                      output int lat);
    drive(we, a, s, d);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      // Garble the bus after acceptance; the latched request must win.
      if (i == 2) begin
        bus.ADR = ~a; bus.DAT_M = ~d;
      end
      if (bus.ACK) begin
        lat = i;
        break;
      end
    end
    #1;
    bus.CYC = 0; bus.STB = 0;
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: got no ACK want ACK @%0t", $time);
    end
  endtask

  localparam logic [127:0] D0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] D3 = 128'h0F0E0D0C0B0A090807060504030201FF;
  localparam logic [127:0] P2 = 128'h2222_1111_AAAA_5555_DEAD_BEEF_0123_4567;

  initial begin
    int lat;
    int pulses;
    logic [15:0] ab0;
    idle_bus();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_ack", 128'(bus.ACK), 128'(0));
    chk("rst_dat", bus.DAT_S, '0);
    chk("rst_cnt", 128'({rd_count, wr_count, abort_count}), 128'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    xfer(1, 12'h010, 16'hFFFF, D0, lat);
    chk("t1_lat", 128'(lat), 128'(L));
    chk("t1_wr", 128'(wr_count), 128'(1));

    xfer(0, 12'h010, 16'h0000, '0, lat);
    chk("t2_lat", 128'(lat), 128'(L));
    chk("t2_dat", bus.DAT_S, D0);
    chk("t2_rd", 128'(rd_count), 128'(1));

    xfer(1, 12'h010, 16'h0001, {128{1'b1}}, lat);
    xfer(0, 12'h010, 16'h0000, '0, lat);
    chk("t3_dat", bus.DAT_S, D3);

    xfer(1, 12'h020, 16'hFFFF, P2, lat);
    drive(1, 12'h020, 16'hFFFF, ~P2);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ACK) pulses++;
    end
    #1 bus.CYC = 0; bus.STB = 0;
    repeat (2) @(negedge clk);
    chk("t4_noack", 128'(pulses), 128'(0));
    chk("t4_abort", 128'(abort_count), 128'(1));
    xfer(0, 12'h020, 16'h0000, '0, lat);
    chk("t4_dat", bus.DAT_S, P2);

    xfer(1, 12'h010, 16'h0000, {32{4'hA}}, lat);
    xfer(0, 12'h010, 16'h0000, '0, lat);
    chk("sel0_dat", bus.DAT_S, D3);

    ab0 = abort_count;
    drive(0, 12'h020, 16'h0000, '0);
    pulses = 0;
    for (int i = 0; i < 40 && !bus.ACK; i++) @(negedge clk);
    if (bus.ACK) pulses++;
    repeat (3) begin
      @(negedge clk);
      if (bus.ACK) pulses++;
    end
    #1 bus.CYC = 0; bus.STB = 0;
    repeat (2) @(negedge clk);
    chk("t5_pulses", 128'(pulses), 128'(1));
    chk("t5_reaccept", 128'(abort_count), 128'(ab0 + 16'd1));

    drive(1, 12'h030, 16'hFFFF, P2);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_ack", 128'(bus.ACK), 128'(0));
    chk("t6_cnt", 128'({rd_count, wr_count, abort_count}), 128'(0));
    bus.CYC = 0; bus.STB = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    xfer(0, 12'h010, 16'h0000, '0, lat);
    chk("t6_lat", 128'(lat), 128'(L));
    chk("t6_rd", 128'(rd_count), 128'(1));
    chk("t6_dat", bus.DAT_S, D3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
